// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache controller.
// Holds the FSM state encoding, the store strobe width and the byte-merge helper.
package dcache_pkg;

    localparam int WSTRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WB     = 2'd1,
        ST_REFILL = 2'd2
    } state_e;

    // Byte i of the result comes from new_w when strb[i] is set, else from old_w.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0]        old_w,
        input logic [31:0]        new_w,
        input logic [WSTRB_W-1:0] strb
    );
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < WSTRB_W; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the cache: one combinational read port and one
// synchronous write port; only valid and dirty are cleared by reset.
module dcache_array #(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_idx_i,
    output logic                   rd_valid_o,
    output logic                   rd_dirty_o,
    output logic [TAG_WIDTH-1:0]   rd_tag_o,
    output logic [31:0]            rd_data_o,
    input  logic [INDEX_WIDTH-1:0] wr_idx_i,
    input  logic                   wr_meta_en_i,
    input  logic                   wr_valid_i,
    input  logic                   wr_dirty_i,
    input  logic [TAG_WIDTH-1:0]   wr_tag_i,
    input  logic                   wr_data_en_i,
    input  logic [31:0]            wr_data_i
);

    localparam int NLINES = 1 << INDEX_WIDTH;

    logic [NLINES-1:0]    valid_q;
    logic [NLINES-1:0]    dirty_q;
    logic [TAG_WIDTH-1:0] tag_q  [NLINES];
    logic [31:0]          data_q [NLINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_meta_en_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
            dirty_q[wr_idx_i] <= wr_dirty_i;
        end
    end

    // Tag and data contents survive reset; a cleared valid bit hides them.
    always_ff @(posedge clk) begin
        if (wr_meta_en_i) tag_q[wr_idx_i] <= wr_tag_i;
        if (wr_data_en_i) data_q[wr_idx_i] <= wr_data_i;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller (one word per line).
// Hits complete combinationally; misses stall through an optional write-back then a refill.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_WIDTH = 6,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [WSTRB_W-1:0]    cpu_wstrb,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout,
    input  logic                  mem_ack,
    output state_e                dbg_state_o
);

    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:2]   miss_addr_q;
    logic                    miss_we_q;
    logic [31:0]             miss_wdata_q;
    logic [WSTRB_W-1:0]      miss_wstrb_q;

    logic [ADDR_WIDTH-1:2]   lk_addr;
    logic [INDEX_WIDTH-1:0]  lk_idx;
    logic [TAG_W-1:0]        lk_tag;
    logic                    rd_valid;
    logic                    rd_dirty;
    logic [TAG_W-1:0]        rd_tag;
    logic [31:0]             rd_data;
    logic                    hit;

    logic                    wr_meta_en;
    logic                    wr_valid;
    logic                    wr_dirty;
    logic [TAG_W-1:0]        wr_tag;
    logic                    wr_data_en;
    logic [31:0]             wr_data;

    logic                    unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    // While a miss is in flight the array is indexed by the latched address, so the
    // read port shows the victim during WB and the target line during REFILL.
    assign lk_addr = (state_q == ST_IDLE) ? cpu_addr[ADDR_WIDTH-1:2] : miss_addr_q;
    assign lk_idx  = lk_addr[INDEX_WIDTH+1:2];
    assign lk_tag  = lk_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];

    dcache_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_W)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .rd_idx_i     (lk_idx),
        .rd_valid_o   (rd_valid),
        .rd_dirty_o   (rd_dirty),
        .rd_tag_o     (rd_tag),
        .rd_data_o    (rd_data),
        .wr_idx_i     (lk_idx),
        .wr_meta_en_i (wr_meta_en),
        .wr_valid_i   (wr_valid),
        .wr_dirty_i   (wr_dirty),
        .wr_tag_i     (wr_tag),
        .wr_data_en_i (wr_data_en),
        .wr_data_i    (wr_data)
    );

    assign hit         = cpu_req & rd_valid & (rd_tag == lk_tag);
    assign cpu_rdata   = rd_data;
    assign dbg_state_o = state_q;

    always_comb begin
        cpu_stall  = 1'b0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        wr_meta_en = 1'b0;
        wr_valid   = 1'b0;
        wr_dirty   = 1'b0;
        wr_tag     = lk_tag;
        wr_data_en = 1'b0;
        wr_data    = rd_data;
        case (state_q)
            ST_IDLE: begin
                cpu_stall = cpu_req & ~hit;
                if (hit && cpu_we) begin
                    wr_meta_en = 1'b1;
                    wr_valid   = 1'b1;
                    wr_dirty   = 1'b1;
                    wr_data_en = 1'b1;
                    wr_data    = merge_bytes(rd_data, cpu_wdata, cpu_wstrb);
                end
            end
            ST_WB: begin
                cpu_stall = 1'b1;
                mem_cs    = ~mem_ack;
                mem_we    = 1'b1;
                mem_addr  = {rd_tag, lk_idx, 2'b00};
                mem_din   = rd_data;
            end
            ST_REFILL: begin
                cpu_stall = 1'b1;
                mem_cs    = ~mem_ack;
                mem_addr  = {miss_addr_q, 2'b00};
                if (mem_ack) begin
                    wr_meta_en = 1'b1;
                    wr_valid   = 1'b1;
                    wr_dirty   = miss_we_q;
                    wr_data_en = 1'b1;
                    wr_data    = miss_we_q ? merge_bytes(mem_dout, miss_wdata_q, miss_wstrb_q)
                                           : mem_dout;
                end
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req && !hit) begin
                        state_q <= (rd_valid && rd_dirty) ? ST_WB : ST_REFILL;
                    end
                end
                ST_WB: begin
                    if (mem_ack) state_q <= ST_REFILL;
                end
                ST_REFILL: begin
                    if (mem_ack) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The request is captured once at miss detection; later cpu_* changes do not
    // affect the in-flight miss.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && cpu_req && !hit) begin
            miss_addr_q  <= cpu_addr[ADDR_WIDTH-1:2];
            miss_we_q    <= cpu_we;
            miss_wdata_q <= cpu_wdata;
            miss_wstrb_q <= cpu_wstrb;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a 4-cycle-response RAM model and a
// transaction log used to check RAM traffic, stall lengths and returned data.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int IW = 6;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [3:0]    cpu_wstrb = '0;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;
    logic          mem_ack;
    state_e        dbg_state;

    logic          ram_ack = 1'b0;
    logic [31:0]   ram_dout = '0;
    logic          ack_inj = 1'b0;
    logic [1:0]    ram_cnt = '0;
    logic          ram_init_done = 1'b0;
    logic [31:0]   ram [0:1023];

    int n_rd = 0;
    int n_wr = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    int cs_ack_viol = 0;
    int cs_cycles = 0;

    int n_cmp = 0;
    int n_err = 0;

    assign mem_ack  = ram_ack | ack_inj;
    assign mem_dout = ram_dout;

    dcache_ctrl #(.INDEX_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_wstrb   (cpu_wstrb),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .mem_ack     (mem_ack),
        .dbg_state_o (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // RAM model: ack arrives 4 cycles after cs first rises; dout is non-zero only with ack.
    always @(posedge clk) begin
        if (!ram_init_done) begin
            ram[10'h040] <= 32'hDEADBEEF;
            ram[10'h041] <= 32'hAABBCCDD;
            ram[10'h081] <= 32'h55667788;
            ram[10'h0C2] <= 32'h0BADF00D;
            ram_init_done <= 1'b1;
        end else if (ram_ack) begin
            ram_ack  <= 1'b0;
            ram_dout <= '0;
            ram_cnt  <= '0;
        end else if (mem_cs) begin
            if (ram_cnt == 2'd3) begin
                ram_ack <= 1'b1;
                ram_cnt <= '0;
                if (mem_we) begin
                    ram[mem_addr[11:2]] <= mem_din;
                    n_wr         <= n_wr + 1;
                    last_wr_addr <= mem_addr;
                    last_wr_data <= mem_din;
                end else begin
                    ram_dout     <= ram[mem_addr[11:2]];
                    n_rd         <= n_rd + 1;
                    last_rd_addr <= mem_addr;
                end
            end else begin
                ram_cnt <= ram_cnt + 2'd1;
            end
        end else begin
            ram_cnt <= '0;
        end
    end

    always @(negedge clk) begin
        if (mem_ack && mem_cs) cs_ack_viol <= cs_ack_viol + 1;
        if (mem_cs) cs_cycles <= cs_cycles + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a request and count stalled cycles until it completes (bounded).
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output int stalls, output logic [31:0] rdata);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wstrb = strb;
        #1;
        stalls = 0;
        while (cpu_stall && stalls < 50) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rdata = cpu_rdata;
    endtask

    task automatic go_idle();
        @(negedge clk);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    initial begin
        int          st;
        logic [31:0] rd;
        int          cs_before;
        int          wait_cnt;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_stall", 32'(cpu_stall), 32'd0);
        check_val("rst_cs", 32'(mem_cs), 32'd0);
        check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // cold load
        access(1'b0, 32'h100, 32'h0, 4'h0, st, rd);
        check_val("cold_stall", 32'(st), 32'd6);
        check_val("cold_rdata", rd, 32'hDEADBEEF);
        check_val("cold_nrd", 32'(n_rd), 32'd1);
        check_val("cold_rdaddr", last_rd_addr, 32'h100);
        access(1'b0, 32'h100, 32'h0, 4'h0, st, rd);
        check_val("rehit_stall", 32'(st), 32'd0);
        check_val("rehit_rdata", rd, 32'hDEADBEEF);

        // store miss with partial strobe
        access(1'b1, 32'h104, 32'h11223344, 4'b0011, st, rd);
        check_val("stmiss_stall", 32'(st), 32'd6);
        check_val("stmiss_nrd", 32'(n_rd), 32'd2);
        access(1'b0, 32'h104, 32'h0, 4'h0, st, rd);
        check_val("stmiss_ld_stall", 32'(st), 32'd0);
        check_val("stmiss_ld_rdata", rd, 32'hAABB3344);
        check_val("stmiss_nwr", 32'(n_wr), 32'd0);

        // back-to-back store hits
        cs_before = cs_cycles;
        access(1'b1, 32'h100, 32'h01020304, 4'b1111, st, rd);
        check_val("b2b_st0_stall", 32'(st), 32'd0);
        access(1'b1, 32'h104, 32'hCAFEF00D, 4'b1100, st, rd);
        check_val("b2b_st1_stall", 32'(st), 32'd0);
        access(1'b0, 32'h100, 32'h0, 4'h0, st, rd);
        check_val("b2b_ld0", rd, 32'h01020304);
        access(1'b0, 32'h104, 32'h0, 4'h0, st, rd);
        check_val("b2b_ld1", rd, 32'hCAFE3344);
        check_val("b2b_cs_quiet", 32'(cs_cycles - cs_before), 32'd0);

        // conflict miss on a dirty line
        access(1'b0, 32'h204, 32'h0, 4'h0, st, rd);
        check_val("dirty_stall", 32'(st), 32'd11);
        check_val("dirty_nwr", 32'(n_wr), 32'd1);
        check_val("dirty_wraddr", last_wr_addr, 32'h104);
        check_val("dirty_wrdata", last_wr_data, 32'hCAFE3344);
        check_val("dirty_nrd", 32'(n_rd), 32'd3);
        check_val("dirty_rdaddr", last_rd_addr, 32'h204);
        check_val("dirty_rdata", rd, 32'h55667788);

        // zero-strobe store still marks the line dirty
        access(1'b1, 32'h204, 32'hFFFFFFFF, 4'b0000, st, rd);
        check_val("zstrb_stall", 32'(st), 32'd0);
        access(1'b0, 32'h104, 32'h0, 4'h0, st, rd);
        check_val("zstrb_evict_stall", 32'(st), 32'd11);
        check_val("zstrb_wrdata", last_wr_data, 32'h55667788);
        check_val("zstrb_wraddr", last_wr_addr, 32'h204);
        check_val("zstrb_rdata", rd, 32'hCAFE3344);

        // stray ack while idle
        go_idle();
        @(negedge clk);
        ack_inj = 1'b1;
        @(negedge clk);
        ack_inj = 1'b0;
        #1;
        check_val("inj_state", 32'(dbg_state), 32'(ST_IDLE));
        check_val("inj_cs", 32'(mem_cs), 32'd0);
        access(1'b0, 32'h100, 32'h0, 4'h0, st, rd);
        check_val("inj_hit_stall", 32'(st), 32'd0);
        check_val("inj_hit_rdata", rd, 32'h01020304);

        // reset during refill
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h308;
        wait_cnt = 0;
        #1;
        while (!mem_cs && wait_cnt < 20) begin
            wait_cnt++;
            @(negedge clk);
            #1;
        end
        check_val("mid_cs_seen", 32'(mem_cs), 32'd1);
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("mid_state", 32'(dbg_state), 32'(ST_IDLE));
        check_val("mid_cs", 32'(mem_cs), 32'd0);
        check_val("mid_stall", 32'(cpu_stall), 32'd0);
        access(1'b0, 32'h308, 32'h0, 4'h0, st, rd);
        check_val("mid_reload_stall", 32'(st), 32'd6);
        check_val("mid_reload_rdata", rd, 32'h0BADF00D);
        access(1'b0, 32'h100, 32'h0, 4'h0, st, rd);
        check_val("mid_lost_stall", 32'(st), 32'd6);
        check_val("mid_lost_rdata", rd, 32'hDEADBEEF);
        check_val("mid_nwr", 32'(n_wr), 32'd2);
        check_val("mid_nrd", 32'(n_rd), 32'd6);
        go_idle();

        repeat (2) @(negedge clk);
        check_val("cs_ack_overlap", 32'(cs_ack_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache placed between the CPU load/store stage and the multi-cycle data_ram memory model.
- Hits complete in the same cycle without stalling.
- Misses stall the CPU while the controller writes back a dirty victim (if any) and then refills the line over the RAM's cs/we/ack handshake.
- Each line holds one 32-bit word, so refill and write-back are single RAM transactions.

Parameters:
INDEX_WIDTH, 6, log2 of the number of lines (64 lines).
ADDR_WIDTH, 32, width of CPU and memory byte addresses.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
cpu_req  in  1  load/store request valid.
cpu_we  in  1  1 = store, 0 = load.
cpu_addr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored.
cpu_wdata  in  32  store data.
cpu_wstrb  in  4  store byte enables; bit i covers byte i.
cpu_rdata  out  32  load data; valid when cpu_req=1 and cpu_stall=0.
cpu_stall  out  1  CPU must hold its request stable.
mem_cs  out  1  RAM chip select.
mem_we  out  1  RAM write enable.
mem_addr  out  ADDR_WIDTH  RAM word address, with bits [1:0]=0.
mem_din  out  32  RAM write data.
mem_dout  in  32  RAM read data; valid only in the mem_ack cycle.
mem_ack  in  1  RAM one-cycle completion pulse.

Behaviour:
- Address split: index = addr[INDEX_WIDTH+1:2]; tag = addr[ADDR_WIDTH-1:INDEX_WIDTH+2].
- hit = cpu_req & valid[index] & (tag_arr[index]==tag).
- States: IDLE, WB, REFILL.
- IDLE:
  - cpu_stall = cpu_req & ~hit.
  - Load hit: cpu_rdata = data[index] combinationally.
  - Store hit: at the clock edge, merge the strobed bytes into data[index] and set dirty.
  - Miss: latch addr, we, wdata and wstrb into miss registers. Go to WB if the victim is valid and dirty, otherwise go to REFILL.
- WB:
  - cpu_stall=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_din=victim data.
  - On mem_ack, go to REFILL.
- REFILL:
  - cpu_stall=1, mem_we=0, mem_addr={latched tag, index, 2'b00}.
  - On mem_ack, install mem_dout, set valid, store the tag, and go to IDLE.
  - If the latched request is a store, merge the latched wdata/wstrb into the installed word and set dirty=1; otherwise dirty=0.
- mem_cs = (state==WB | state==REFILL) & ~mem_ack. cs drops combinationally in the ack cycle, so the RAM returns to idle; there is therefore a mandatory cs-low cycle between the WB and REFILL transactions.
- mem_dout is sampled only in the ack cycle; it reads 0 otherwise.
- Re-lookup after a miss: after REFILL the controller returns to IDLE and looks the request up again; this lookup hits. With the RAM's 4-cycle response (ack arrives 4 cycles after cs first rises):
  - Clean miss: cpu_stall high 6 cycles.
  - Dirty miss: cpu_stall high 11 cycles.
- In IDLE, mem_cs=0, mem_we=0, and mem_addr/mem_din are don't-care (drive 0).
- Reset:
  - State goes to IDLE and all valid and dirty bits are cleared.
  - mem_cs=0 and cpu_stall=0 from the cycle after the reset edge.
  - Data and tag arrays are not cleared.
  - A reset mid-transaction abandons it. The latched store is lost and no write-back occurs.
- cpu_req changing during a stall: the in-flight miss completes for the latched address. The new request is looked up in IDLE afterwards.
- cpu_wstrb=0 on a store: the access is treated as a store that changes no bytes but still sets dirty.
- Unaligned addresses: ignored; only word granularity is supported.

Decomposition:
- Package dcache_pkg: state encoding (IDLE=0, WB=1, REFILL=2), the constant WSTRB_W=4, and a byte-merge function (old word, new word, strb → merged word).
- Sub-module dcache_array: tag, valid, dirty and data storage.
  - One combinational read port indexed by index.
  - One synchronous write port with separate write enables for tag/valid/dirty and for data.
  - Synchronous clear of valid/dirty on rst.

Test Plan:
- Cold load 0x100, with RAM word 0x40 = 0xDEADBEEF → cpu_stall high 6 cycles, one RAM read at 0x100, then cpu_rdata=0xDEADBEEF with stall low; a repeat load of 0x100 hits with zero stall.
- Store 0x104 with data 0x11223344 and wstrb=4'b0011 on a clean miss (RAM holds 0xAABBCCDD) → refill, then line = 0xAABB3344 with dirty=1; a subsequent load returns 0xAABB3344 with no RAM traffic.
- Conflict: dirty line at 0x104, then load 0x104+(1<<(INDEX_WIDTH+2)) → RAM write of 0xAABB3344 to 0x104, one cs-low cycle, RAM read of the new address, stall high 11 cycles.
- Back-to-back store hits to 0x100 and 0x100+4 in consecutive cycles → no stall, mem_cs stays 0, and both words update.
- Check mem_cs is low in every mem_ack cycle and the RAM never enters READING1 spuriously; mem_ack asserted while in IDLE is ignored.
- Assert rst during REFILL (2 cycles after cs rises) → the next cycle shows state IDLE, mem_cs=0 and cpu_stall=0; a following load to the same address misses again (valid was cleared).
